// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM/WB stage (master) and the memory (slave).
interface mem_wb_stage_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 48
);
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic              memAck;
    logic [DATA_W-1:0] memRData;

    modport master (output memReq, memWe, memAddr, memWData, input memAck, memRData);
    modport slave  (input memReq, memWe, memAddr, memWData, output memAck, memRData);
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: M register, req/ack data-memory access with stall, W register with bubbles.
// Optional macro MEM_TIMEOUT_EN adds a WAIT-state watchdog that aborts a stuck access and sets memErr.
module mem_wb_stage #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 48,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWriteE,
    input  logic              PCSrcE,
    input  logic              memToRegE,
    input  logic              memWriteE,
    input  logic [3:0]        WA3E,
    input  logic [DATA_W-1:0] postAluResult,
    input  logic [DATA_W-1:0] srcB,
    mem_wb_stage_if.master    mem,
    output logic [DATA_W-1:0] resultW,
    output logic [3:0]        WA3W,
    output logic              regWriteW,
    output logic              PCSrcW,
    output logic              stallM,
    output logic              memErr
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic              reg_write;
        logic              pcsrc;
        logic              mem_to_reg;
        logic              mem_write;
        logic [3:0]        wa3;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] srcb;
    } m_t;

    typedef struct packed {
        logic              reg_write;
        logic              pcsrc;
        logic [3:0]        wa3;
        logic [DATA_W-1:0] result;
    } w_t;

    state_t state_q, state_d;
    m_t     m_q, m_d;
    w_t     w_q, w_d;
    logic   mem_req;
    logic   timeout_hit;

    // NOTE: asynchronous reset and non-blocking updates so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (mem_req && !mem.memAck) state_d = S_WAIT;
            S_WAIT:  if ((mem_req && mem.memAck) || timeout_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A store with memToReg also set is still a store; the request drops once the watchdog fires.
    always_comb begin
        mem_req = (m_q.mem_write | m_q.mem_to_reg) & ~timeout_hit;
        stallM  = mem_req & ~mem.memAck;
    end

    assign mem.memReq   = mem_req;
    assign mem.memWe    = mem_req & m_q.mem_write;
    assign mem.memAddr  = m_q.alu[ADDR_W-1:0];
    assign mem.memWData = m_q.srcb;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    assign timeout_hit = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT));
    assign cnt_d       = (state_q == S_WAIT) ? cnt_q + CNT_W'(1) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | timeout_hit;
        end
    end

    assign memErr = err_q;
`else
    assign timeout_hit = 1'b0;
    assign memErr      = 1'b0;
`endif

    always_comb begin
        m_d = m_q;
        if (!stallM) begin
            m_d.reg_write  = regWriteE;
            m_d.pcsrc      = PCSrcE;
            m_d.mem_to_reg = memToRegE;
            m_d.mem_write  = memWriteE;
            m_d.wa3        = WA3E;
            m_d.alu        = postAluResult;
            m_d.srcb       = srcB;
        end
    end

    // Stalled cycles leave a bubble in W: data held, write and branch enables dropped.
    always_comb begin
        w_d           = w_q;
        w_d.reg_write = 1'b0;
        w_d.pcsrc     = 1'b0;
        if (!stallM) begin
            w_d.reg_write = m_q.reg_write & ~timeout_hit;
            w_d.pcsrc     = m_q.pcsrc;
            w_d.wa3       = m_q.wa3;
            w_d.result    = (m_q.mem_to_reg && !m_q.mem_write && mem_req && mem.memAck)
                          ? mem.memRData : m_q.alu;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q <= '0;
            w_q <= '0;
        end else begin
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign resultW   = w_q.result;
    assign WA3W      = w_q.wa3;
    assign regWriteW = w_q.reg_write;
    assign PCSrcW    = w_q.pcsrc;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage: cycle-by-cycle expected outputs plus reset/timeout sequences.
module tb_mem_wb_stage;
`ifdef MEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    typedef struct packed {
        logic        rw;
        logic        pc;
        logic        m2r;
        logic        mw;
        logic [3:0]  wa3;
        logic [47:0] alu;
        logic [47:0] srcb;
    } ins_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [47:0] wdata;
        logic        stall;
        logic        rw;
        logic        pc;
        logic [3:0]  wa3;
        logic [47:0] res;
        logic        err;
    } out_t;

    typedef struct {
        ins_t        e;
        logic        ack;
        logic [47:0] rd;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        regWriteE, PCSrcE, memToRegE, memWriteE;
    logic [3:0]  WA3E;
    logic [47:0] postAluResult, srcB;
    logic [47:0] resultW;
    logic [3:0]  WA3W;
    logic        regWriteW, PCSrcW, stallM, memErr;

    int n_vec = 0;
    int n_err = 0;

    mem_wb_stage_if #(.ADDR_W(16), .DATA_W(48)) bus ();

    mem_wb_stage #(.ADDR_W(16), .DATA_W(48), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .regWriteE     (regWriteE),
        .PCSrcE        (PCSrcE),
        .memToRegE     (memToRegE),
        .memWriteE     (memWriteE),
        .WA3E          (WA3E),
        .postAluResult (postAluResult),
        .srcB          (srcB),
        .mem           (bus),
        .resultW       (resultW),
        .WA3W          (WA3W),
        .regWriteW     (regWriteW),
        .PCSrcW        (PCSrcW),
        .stallM        (stallM),
        .memErr        (memErr)
    );

    always #5 clk = ~clk;

    function automatic ins_t mk_ins(input logic rw, input logic pc, input logic m2r, input logic mw,
                                    input logic [3:0] wa3, input logic [47:0] alu, input logic [47:0] srcb);
        ins_t i;
        i.rw = rw; i.pc = pc; i.m2r = m2r; i.mw = mw; i.wa3 = wa3; i.alu = alu; i.srcb = srcb;
        return i;
    endfunction

    function automatic out_t mk_out(input logic req, input logic we, input logic [15:0] addr,
                                    input logic [47:0] wdata, input logic stall, input logic rw,
                                    input logic pc, input logic [3:0] wa3, input logic [47:0] res,
                                    input logic err);
        out_t o;
        o.req = req; o.we = we; o.addr = addr; o.wdata = wdata; o.stall = stall;
        o.rw = rw; o.pc = pc; o.wa3 = wa3; o.res = res; o.err = err;
        return o;
    endfunction

    function automatic vec_t mk_vec(input ins_t e, input logic ack, input logic [47:0] rd, input out_t exp);
        vec_t v;
        v.e = e; v.ack = ack; v.rd = rd; v.exp = exp;
        return v;
    endfunction

    function automatic out_t sample();
        return mk_out(bus.memReq, bus.memWe, bus.memAddr, bus.memWData, stallM,
                      regWriteW, PCSrcW, WA3W, resultW, memErr);
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("req=%b we=%b addr=%h wdata=%h stall=%b rw=%b pc=%b wa3=%0d res=%h err=%b",
                         o.req, o.we, o.addr, o.wdata, o.stall, o.rw, o.pc, o.wa3, o.res, o.err);
    endfunction

    // Address and write data are only meaningful while a request (resp. a write) is expected.
    task automatic check(input string name, input out_t exp, input bit full);
        out_t g = sample();
        out_t e = exp;
        if (!full) begin
            if (!e.req) begin g.addr = '0; e.addr = '0; end
            if (!e.we)  begin g.wdata = '0; e.wdata = '0; end
        end
        n_vec++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s: got %s | want %s", name, fmt(sample()), fmt(exp));
        end
    endtask

    task automatic step(input ins_t e, input logic ack, input logic [47:0] rd);
        @(posedge clk);
        #1;
        regWriteE = e.rw; PCSrcE = e.pc; memToRegE = e.m2r; memWriteE = e.mw;
        WA3E = e.wa3; postAluResult = e.alu; srcB = e.srcb;
        bus.memAck = ack; bus.memRData = rd;
        @(negedge clk);
    endtask

    vec_t vecs[17];
    ins_t nop, alu1, ld1, st1, lda, ldb, br, both, ld8, alu4;
    out_t zero;

    initial begin
        nop  = mk_ins(0, 0, 0, 0, 4'd0, 48'h0, 48'h0);
        alu1 = mk_ins(1, 0, 0, 0, 4'd3, 48'h0102030405FF, 48'h0);
        ld1  = mk_ins(1, 0, 1, 0, 4'd5, 48'h123400000010, 48'h0);
        st1  = mk_ins(0, 0, 0, 1, 4'd0, 48'h000000000020, 48'h112233445566);
        lda  = mk_ins(1, 0, 1, 0, 4'd6, 48'h000000000030, 48'h0);
        ldb  = mk_ins(1, 0, 1, 0, 4'd7, 48'h000000000040, 48'h0);
        br   = mk_ins(0, 1, 0, 0, 4'd0, 48'h000000000100, 48'h0);
        both = mk_ins(1, 0, 1, 1, 4'd9, 48'h000000000050, 48'h000000000ABC);
        ld8  = mk_ins(1, 0, 1, 0, 4'd8, 48'h000000000060, 48'h0);
        alu4 = mk_ins(1, 0, 0, 0, 4'd4, 48'h000000000099, 48'h0);
        zero = '0;

        // ALU op, load with 3 wait cycles, store, back-to-back loads (0 and 2 waits), branch, store+memToReg.
        vecs[0]  = mk_vec(alu1, 0, 48'h0, zero);
        vecs[1]  = mk_vec(nop,  0, 48'h0, zero);
        vecs[2]  = mk_vec(ld1,  0, 48'h0, mk_out(0, 0, 16'h0, 48'h0, 0, 1, 0, 4'd3, 48'h0102030405FF, 0));
        vecs[3]  = mk_vec(nop,  0, 48'h0, mk_out(1, 0, 16'h0010, 48'h0, 1, 0, 0, 4'd0, 48'h0, 0));
        vecs[4]  = mk_vec(nop,  0, 48'h0, mk_out(1, 0, 16'h0010, 48'h0, 1, 0, 0, 4'd0, 48'h0, 0));
        vecs[5]  = mk_vec(nop,  0, 48'h0, mk_out(1, 0, 16'h0010, 48'h0, 1, 0, 0, 4'd0, 48'h0, 0));
        vecs[6]  = mk_vec(nop,  1, 48'hAABBCCDDEEFF, mk_out(1, 0, 16'h0010, 48'h0, 0, 0, 0, 4'd0, 48'h0, 0));
        vecs[7]  = mk_vec(st1,  0, 48'h0, mk_out(0, 0, 16'h0, 48'h0, 0, 1, 0, 4'd5, 48'hAABBCCDDEEFF, 0));
        vecs[8]  = mk_vec(lda,  1, 48'h5A5A5A5A5A5A,
                          mk_out(1, 1, 16'h0020, 48'h112233445566, 0, 0, 0, 4'd0, 48'h0, 0));
        vecs[9]  = mk_vec(ldb,  1, 48'h010101010101,
                          mk_out(1, 0, 16'h0030, 48'h0, 0, 0, 0, 4'd0, 48'h000000000020, 0));
        vecs[10] = mk_vec(br,   0, 48'h0, mk_out(1, 0, 16'h0040, 48'h0, 1, 1, 0, 4'd6, 48'h010101010101, 0));
        vecs[11] = mk_vec(br,   0, 48'h0, mk_out(1, 0, 16'h0040, 48'h0, 1, 0, 0, 4'd6, 48'h010101010101, 0));
        vecs[12] = mk_vec(br,   1, 48'h020202020202,
                          mk_out(1, 0, 16'h0040, 48'h0, 0, 0, 0, 4'd6, 48'h010101010101, 0));
        vecs[13] = mk_vec(both, 1, 48'hFFFFFFFFFFFF, mk_out(0, 0, 16'h0, 48'h0, 0, 1, 0, 4'd7, 48'h020202020202, 0));
        vecs[14] = mk_vec(nop,  1, 48'h3C3C3C3C3C3C,
                          mk_out(1, 1, 16'h0050, 48'h000000000ABC, 0, 0, 1, 4'd0, 48'h000000000100, 0));
        vecs[15] = mk_vec(nop,  0, 48'h0, mk_out(0, 0, 16'h0, 48'h0, 0, 1, 0, 4'd9, 48'h000000000050, 0));
        vecs[16] = mk_vec(nop,  0, 48'h0, zero);

        rst = 1'b0;
        regWriteE = 0; PCSrcE = 0; memToRegE = 0; memWriteE = 0;
        WA3E = '0; postAluResult = '0; srcB = '0;
        bus.memAck = 1'b0; bus.memRData = '0;
        #2;
        check("reset_state", zero, 1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].e, vecs[i].ack, vecs[i].rd);
            check($sformatf("vec%0d", i), vecs[i].exp, 0);
        end

        // Reset asserted in the second WAIT cycle of a load: everything clears at once, no writeback.
        step(ld8, 0, 48'h0);
        step(alu4, 0, 48'h0);
        check("rst_req_cycle", mk_out(1, 0, 16'h0060, 48'h0, 1, 0, 0, 4'd0, 48'h0, 0), 0);
        step(alu4, 0, 48'h0);
        check("rst_wait1", mk_out(1, 0, 16'h0060, 48'h0, 1, 0, 0, 4'd0, 48'h0, 0), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_in_wait", zero, 1);
        regWriteE = 0; PCSrcE = 0; memToRegE = 0; memWriteE = 0;
        WA3E = '0; postAluResult = '0; srcB = '0;
        bus.memAck = 1'b1; bus.memRData = 48'hEEEEEEEEEEEE;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(nop, 1, 48'hEEEEEEEEEEEE);
            check($sformatf("post_rst%0d", i), zero, 1);
        end

`ifdef MEM_TIMEOUT_EN
        // Load with memAck stuck low: 1 request cycle + 4 WAIT cycles stalled, then abort without writeback.
        step(mk_ins(1, 0, 1, 0, 4'd10, 48'h000000000070, 48'h0), 0, 48'h0);
        for (int i = 0; i < 5; i++) begin
            step(mk_ins(1, 0, 0, 0, 4'd2, 48'h7, 48'h0), 0, 48'h0);
            check($sformatf("to_stall%0d", i), mk_out(1, 0, 16'h0070, 48'h0, 1, 0, 0, 4'd0, 48'h0, 0), 0);
        end
        step(mk_ins(1, 0, 0, 0, 4'd2, 48'h7, 48'h0), 0, 48'h0);
        check("to_abort", mk_out(0, 0, 16'h0, 48'h0, 0, 0, 0, 4'd0, 48'h0, 0), 0);
        step(nop, 0, 48'h0);
        check("to_nowrite", mk_out(0, 0, 16'h0, 48'h0, 0, 0, 0, 4'd10, 48'h000000000070, 1), 0);
        step(nop, 0, 48'h0);
        check("to_next_ok", mk_out(0, 0, 16'h0, 48'h0, 0, 1, 0, 4'd2, 48'h7, 1), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
